dht11_reader: RTL and testbench

//  Single-wire DHT11 bus master. On a start request it issues the host start pulse,

---
 rtl/dht11_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_dht11_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// ---------------------------------------------------------------------------
// dht11_reader
// Single-wire DHT11 bus master. A rising edge on i_Start makes the master
// hold the line low for the host start pulse, release it, follow the sensor
// response, then time the 40 data bits. The bits arrive in wire order (hum
// int, hum dec, temp int, temp dec, checksum) and are repacked for the
// downstream protocol core.
//
// Optional feature macro: DHT_CHECKSUM_EN
//   defined   : the frame is accepted only if the byte sum mod 256 equals the
//               checksum byte, otherwise the transaction ends in an error.
//   undefined : every complete 40-bit frame is accepted.
//
// Ports
//   i_Clock  in     1   system clock
//   i_Reset  in     1   synchronous, active-high reset
//   i_Start  in     1   read request, rising edge starts one transaction
//   io_Dht   inout  1   DHT11 data line, driven low or released (pull-up)
//   o_Data   out    40  [7:0] temp int, [15:8] temp dec, [23:16] hum int,
//                       [31:24] hum dec, [39:32] checksum
//   o_Done   out    1   one-cycle pulse, o_Data holds a new frame
//   o_Error  out    1   one-cycle pulse, timeout or checksum failure
//   o_Busy   out    1   high while a transaction is in progress
// ---------------------------------------------------------------------------
module dht11_reader #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_LOW_US  = 20000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Start,
    inout  wire         io_Dht,
    output logic [39:0] o_Data,
    output logic        o_Done,
    output logic        o_Error,
    output logic        o_Busy
);

    // The phase counter must reach both the start pulse length and one past
    // the timeout; it saturates at all-ones, which is above both.
    localparam int PH_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int PH_W   = $clog2(PH_MAX + 2);
    localparam int TK_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_START_REL,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_dht_s1;
    logic            r_dht_s2;
    logic            r_dht_prev;
    logic            r_start_d;
    logic [TK_W-1:0] r_tick_cnt;
    logic [PH_W-1:0] r_phase_us;
    logic [5:0]      r_bit_cnt;
    logic [39:0]     r_raw;
    logic [39:0]     r_data;

    logic            w_rise;
    logic            w_fall;
    logic            w_start_edge;
    logic            w_tick;
    logic            w_timeout;
    logic            w_start_low_done;
    logic            w_bit_val;
    logic            w_state_chg;
    logic            w_sum_ok;
    logic            w_drive_low;
    logic [39:0]     w_packed;

    // Open-drain style: only ever pull low, otherwise let the pull-up win.
    assign io_Dht = w_drive_low ? 1'b0 : 1'bz;

    // Two-stage synchronizer plus one history stage for edge detection.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_dht_s1   <= 1'b1;
            r_dht_s2   <= 1'b1;
            r_dht_prev <= 1'b1;
        end else begin
            r_dht_s1   <= io_Dht;
            r_dht_s2   <= r_dht_s1;
            r_dht_prev <= r_dht_s2;
        end
    end

    assign w_rise = r_dht_s2 & ~r_dht_prev;
    assign w_fall = ~r_dht_s2 & r_dht_prev;

    // Tracking i_Start even during reset means a level held through reset
    // does not look like a fresh request afterwards.
    always_ff @(posedge i_Clock) begin
        r_start_d <= i_Start;
    end

    assign w_start_edge = i_Start & ~r_start_d;

    // Microsecond time base; both counters restart on every state change so
    // each state measures its own duration.
    assign w_state_chg = (w_next != r_state);
    assign w_tick      = (r_tick_cnt == TK_W'(CLKS_PER_US - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset || w_state_chg) begin
            r_tick_cnt <= '0;
            r_phase_us <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            if (r_phase_us != {PH_W{1'b1}}) begin
                r_phase_us <= r_phase_us + 1'b1;
            end
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_timeout        = (r_phase_us >  PH_W'(TIMEOUT_US));
    assign w_start_low_done = (r_phase_us >= PH_W'(START_LOW_US));
    assign w_bit_val        = (r_phase_us >  PH_W'(BIT_THRESH_US));

    // Wire order is hum int, hum dec, temp int, temp dec, checksum.
    assign w_packed = {r_raw[7:0], r_raw[31:24], r_raw[39:32], r_raw[15:8], r_raw[23:16]};

`ifdef DHT_CHECKSUM_EN
    logic [7:0] w_sum;
    assign w_sum    = r_raw[39:32] + r_raw[31:24] + r_raw[23:16] + r_raw[15:8];
    assign w_sum_ok = (w_sum == r_raw[7:0]);
`else
    assign w_sum_ok = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and outputs. Reset gates the outputs so an aborted
    // transaction releases the line at once and never pulses Done/Error.
    always_comb begin
        w_next      = r_state;
        w_drive_low = 1'b0;
        o_Done      = 1'b0;
        o_Error     = 1'b0;
        o_Busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_next = S_START_LOW;
            end
            S_START_LOW: begin
                w_drive_low = 1'b1;
                if (w_start_low_done) w_next = S_START_REL;
            end
            S_START_REL: begin
                if (w_fall)         w_next = S_RESP_LOW;
                else if (w_timeout) w_next = S_ERR;
            end
            S_RESP_LOW: begin
                if (w_rise)         w_next = S_RESP_HIGH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_RESP_HIGH: begin
                if (w_fall)         w_next = S_BIT_LOW;
                else if (w_timeout) w_next = S_ERR;
            end
            S_BIT_LOW: begin
                if (w_rise)         w_next = S_BIT_HIGH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_BIT_HIGH: begin
                if (w_fall)         w_next = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (w_timeout) w_next = S_ERR;
            end
            S_CHECK: begin
                w_next = w_sum_ok ? S_DONE : S_ERR;
            end
            S_DONE: begin
                o_Done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                o_Error = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        o_Busy = (r_state != S_IDLE);
        if (i_Reset) begin
            w_drive_low = 1'b0;
            o_Done      = 1'b0;
            o_Error     = 1'b0;
            o_Busy      = 1'b0;
        end
    end

    // Bit capture and result register. The result loads on the CHECK->DONE
    // edge so it is first visible in the same cycle as the o_Done pulse.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_bit_cnt <= '0;
            r_raw     <= '0;
            r_data    <= '0;
        end else begin
            if (r_state == S_RESP_HIGH && w_fall) begin
                r_bit_cnt <= '0;
            end
            if (r_state == S_BIT_HIGH && w_fall) begin
                r_raw     <= {r_raw[38:0], w_bit_val};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == S_CHECK && w_sum_ok) begin
                r_data <= w_packed;
            end
        end
    end

    assign o_Data = r_data;

endmodule

// File: tb/tb_dht11_reader.sv
// ---------------------------------------------------------------------------
// tb_dht11_reader
// Bench for dht11_reader with a behavioural DHT11 sensor on a pulled-up
// shared line. Frames are built from named bytes and the expected o_Data is
// assembled from the output byte layout.
// ---------------------------------------------------------------------------
module tb_dht11_reader;

    localparam int CPU = 2;
    localparam int SLU = 100;
    localparam int THR = 50;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        r_sens_low;
    wire         w_dht;
    logic [39:0] o_data;
    logic        o_done;
    logic        o_error;
    logic        o_busy;

    always #5 clk = ~clk;

    assign w_dht = r_sens_low ? 1'b0 : 1'bz;
    pullup (w_dht);

    dht11_reader #(
        .CLKS_PER_US  (CPU),
        .START_LOW_US (SLU),
        .BIT_THRESH_US(THR),
        .TIMEOUT_US   (TMO)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Start(start),
        .io_Dht (w_dht),
        .o_Data (o_data),
        .o_Done (o_done),
        .o_Error(o_error),
        .o_Busy (o_busy)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          n_done   = 0;
    int          n_errp   = 0;
    int          n_both   = 0;
    int          n_txn    = 0;
    int          done_cyc = 0;
    int          last_fall_cyc = 0;
    logic [39:0] done_data = '0;
    logic        busy_q    = 1'b0;
    logic [39:0] exp_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    always @(negedge clk) begin
        busy_q <= o_busy;
        if (o_done) begin
            n_done    <= n_done + 1;
            done_data <= o_data;
            done_cyc  <= cyc;
        end
        if (o_error) n_errp <= n_errp + 1;
        if (o_done && o_error) n_both <= n_both + 1;
        if (o_busy && !busy_q) n_txn <= n_txn + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] make_word(input logic [7:0] hi, input logic [7:0] hd,
                                              input logic [7:0] ti, input logic [7:0] td);
        logic [7:0] cs;
        cs = hi + hd + ti + td;
        return {hi, hd, ti, td, cs};
    endfunction

    // Expected o_Data for a frame given in wire order.
    function automatic logic [39:0] expect_data(input logic [39:0] w);
        logic [7:0] hi, hd, ti, td, cs;
        hi = w[39:32]; hd = w[31:24]; ti = w[23:16]; td = w[15:8]; cs = w[7:0];
        return {cs, hd, hi, td, ti};
    endfunction

    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Sensor: answer the host start pulse and send 'word' MSB first. If
    // stall_bit is 0..39 the line is left high during that bit.
    task automatic sensor_send(input logic [39:0] word, input int stall_bit);
        bit seen;
        int lo_cnt;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (w_dht === 1'b0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errs++;
            $display("FAIL host_start_low: line=%b required=0 within 400 cycles", w_dht);
            return;
        end
        seen = 0;
        lo_cnt = 0;
        for (int i = 0; i < 2 * SLU * CPU && !seen; i++) begin
            @(negedge clk);
            lo_cnt++;
            if (w_dht === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || lo_cnt < SLU * CPU - 2 || lo_cnt > SLU * CPU + 4) begin
            n_errs++;
            $display("FAIL host_start_len: low cycles=%0d required about %0d", lo_cnt, SLU * CPU);
            return;
        end
        wait_us($urandom_range(40, 20));
        r_sens_low = 1'b1; wait_us(80);
        r_sens_low = 1'b0; wait_us(80);
        for (int b = 39; b >= 0; b--) begin
            r_sens_low = 1'b1; wait_us($urandom_range(15, 8));
            r_sens_low = 1'b0;
            if (b == stall_bit) begin
                wait_us(TMO + 100);
                return;
            end
            wait_us(word[b] ? $urandom_range(80, 65) : $urandom_range(30, 20));
        end
        r_sens_low = 1'b1;
        last_fall_cyc = cyc;
        wait_us(50);
        r_sens_low = 1'b0;
        wait_us(20);
    endtask

    task automatic test_reset();
        int d0, e0;
        bit bad;
        rst = 1'b1; start = 1'b0; r_sens_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_busy, o_done, o_error} !== 3'b000 || o_data !== 40'h0 || w_dht !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_state: busy/done/err=%b data=%h line=%b required 000/0/1",
                     {o_busy, o_done, o_error}, o_data, w_dht);
        end
        pulse_start();
        repeat (20) @(negedge clk);
        n_checks++;
        if (w_dht !== 1'b0 || o_busy !== 1'b1) begin
            n_errs++;
            $display("FAIL start_low_drive: line=%b busy=%b required 0/1", w_dht, o_busy);
        end
        d0 = n_done; e0 = n_errp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (w_dht !== 1'b1 || {o_busy, o_done, o_error} !== 3'b000 || o_data !== 40'h0) begin
            n_errs++;
            $display("FAIL reset_abort: line=%b busy/done/err=%b data=%h required 1/000/0",
                     w_dht, {o_busy, o_done, o_error}, o_data);
        end
        rst = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || w_dht !== 1'b1) bad = 1;
        end
        n_checks++;
        if (bad || n_done != d0 || n_errp != e0) begin
            n_errs++;
            $display("FAIL reset_idle: restarted=%0d done+%0d err+%0d required 0/0/0",
                     bad, n_done - d0, n_errp - e0);
        end
    endtask

    task automatic test_frame_basic();
        int d0, e0;
        logic [39:0] w;
        w = 40'h37_00_19_00_50;
        d0 = n_done; e0 = n_errp;
        pulse_start();
        sensor_send(w, -1);
        n_checks++;
        if (n_done - d0 != 1 || n_errp != e0) begin
            n_errs++;
            $display("FAIL basic_pulses: done+%0d err+%0d required 1/0", n_done - d0, n_errp - e0);
        end
        exp_data = 40'h50_00_37_00_19;
        n_checks++;
        if (done_data !== exp_data || o_data !== exp_data) begin
            n_errs++;
            $display("FAIL basic_data: at_done=%h held=%h required %h", done_data, o_data, exp_data);
        end
        n_checks++;
        if (done_cyc - last_fall_cyc != 4) begin
            n_errs++;
            $display("FAIL done_latency: %0d cycles after line fall, required 4", done_cyc - last_fall_cyc);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errs++;
            $display("FAIL basic_busy_end: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_no_ack();
        int d0, e0, rel_cyc, err_cyc;
        bit seen;
        d0 = n_done; e0 = n_errp;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (w_dht === 1'b0) seen = 1;
        end
        for (int i = 0; i < 400 && seen; i++) begin
            @(negedge clk);
            if (w_dht === 1'b1) seen = 0;
        end
        rel_cyc = cyc;
        err_cyc = -1;
        for (int i = 0; i < 1000 && err_cyc < 0; i++) begin
            @(negedge clk);
            if (o_error === 1'b1) err_cyc = cyc;
        end
        n_checks++;
        if (err_cyc < 0 || err_cyc - rel_cyc < TMO * CPU || err_cyc - rel_cyc > TMO * CPU + 10) begin
            n_errs++;
            $display("FAIL noack_timeout: error after %0d cycles required %0d..%0d",
                     err_cyc < 0 ? -1 : err_cyc - rel_cyc, TMO * CPU, TMO * CPU + 10);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_errp - e0 != 1 || n_done != d0 || o_data !== exp_data || o_busy !== 1'b0) begin
            n_errs++;
            $display("FAIL noack_result: err+%0d done+%0d data=%h busy=%b required 1/0/%h/0",
                     n_errp - e0, n_done - d0, o_data, o_busy, exp_data);
        end
    endtask

    task automatic test_checksum();
        int d0, e0;
        d0 = n_done; e0 = n_errp;
        pulse_start();
        sensor_send(40'h37_00_19_00_51, -1);
`ifdef DHT_CHECKSUM_EN
        n_checks++;
        if (n_errp - e0 != 1 || n_done != d0 || o_data !== exp_data) begin
            n_errs++;
            $display("FAIL checksum_bad: err+%0d done+%0d data=%h required 1/0/%h",
                     n_errp - e0, n_done - d0, o_data, exp_data);
        end
`else
        exp_data = 40'h51_00_37_00_19;
        n_checks++;
        if (n_done - d0 != 1 || n_errp != e0 || o_data !== exp_data) begin
            n_errs++;
            $display("FAIL checksum_off: done+%0d err+%0d data=%h required 1/0/%h",
                     n_done - d0, n_errp - e0, o_data, exp_data);
        end
`endif
    endtask

    task automatic test_start_level();
        int d0, t0;
        bit bad;
        logic [39:0] w;
        w = make_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        d0 = n_done; t0 = n_txn;
        @(negedge clk); start = 1'b1;
        fork
            sensor_send(w, -1);
            begin
                repeat (40) @(negedge clk);
                start = 1'b0;
                repeat (2) @(negedge clk);
                start = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (o_busy !== 1'b0) bad = 1;
        end
        exp_data = expect_data(w);
        n_checks++;
        if (n_txn - t0 != 1 || n_done - d0 != 1 || bad) begin
            n_errs++;
            $display("FAIL start_level: txns+%0d done+%0d late_busy=%0d required 1/1/0",
                     n_txn - t0, n_done - d0, bad);
        end
        n_checks++;
        if (o_data !== exp_data) begin
            n_errs++;
            $display("FAIL start_level_data: data=%h required %h", o_data, exp_data);
        end
    endtask

    task automatic test_stall();
        int d0, e0;
        logic [39:0] w;
        w = make_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        d0 = n_done; e0 = n_errp;
        pulse_start();
        sensor_send(w, 17);
        n_checks++;
        if (n_errp - e0 != 1 || n_done != d0 || o_data !== exp_data || o_busy !== 1'b0) begin
            n_errs++;
            $display("FAIL stall_error: err+%0d done+%0d data=%h busy=%b required 1/0/%h/0",
                     n_errp - e0, n_done - d0, o_data, o_busy, exp_data);
        end
        w = make_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        d0 = n_done; e0 = n_errp;
        pulse_start();
        sensor_send(w, -1);
        exp_data = expect_data(w);
        n_checks++;
        if (n_done - d0 != 1 || n_errp != e0 || o_data !== exp_data) begin
            n_errs++;
            $display("FAIL stall_recover: done+%0d err+%0d data=%h required 1/0/%h",
                     n_done - d0, n_errp - e0, o_data, exp_data);
        end
    endtask

    task automatic test_random();
        int d0, e0;
        logic [39:0] w;
        for (int k = 0; k < 3; k++) begin
            w = make_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            d0 = n_done; e0 = n_errp;
            pulse_start();
            sensor_send(w, -1);
            exp_data = expect_data(w);
            n_checks++;
            if (n_done - d0 != 1 || n_errp != e0 || done_data !== exp_data) begin
                n_errs++;
                $display("FAIL random_frame%0d: done+%0d err+%0d data=%h required 1/0/%h",
                         k, n_done - d0, n_errp - e0, done_data, exp_data);
            end
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (n_both != 0) begin
            n_errs++;
            $display("FAIL done_error_overlap: %0d cycles required 0", n_both);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        r_sens_low = 1'b0;
        test_reset();
        test_frame_basic();
        test_no_ack();
        test_checksum();
        test_start_level();
        test_stall();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
